i2c_target_10bit: RTL and testbench

I2C target (slave) with 10-bit addressing. It is the bus-side counterpart of the team's I2C master driver. It watches SCL/SDA from the pins, detects START, repeated START and STOP, and matches the two-byte 10-bit address. It then either delivers written bytes to the user or returns user-supplied bytes on reads, driving SDA open-drain only.

---
 rtl/i2c_target_10bit.sv | 180 ++++++++++++++++++
 tb/tb_i2c_target_10bit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_10bit.sv
// rtl/i2c_target_10bit.sv - I2C target with 10-bit addressing, open-drain SDA, no clock stretching
module i2c_target_10bit #(
  parameter logic [9:0] ADDR = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, RX_BYTE, ACK_RX, TX_BYTE, ACK_TX, WAIT
  } state_t;

  state_t      state, n_state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic [2:0]  cnt, n_cnt;
  logic [7:0]  shreg, n_shreg;
  logic        drive, n_drive;
  logic        phase, n_phase;
  logic [7:0]  n_rx_data;
  logic        n_rx_valid, n_tx_req, n_match, n_busy;

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic hi_ok, load_tx;

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  // SDA moving while SCL is (and was) high is a bus condition, never data
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;
  assign byte_in   = {shreg[6:0], sda};
  assign hi_ok     = (byte_in[7:3] == 5'b11110) && (byte_in[2:1] == ADDR[9:8]);

  // Open-drain: only ever pull low; the register's async reset releases the line immediately
  assign I2C_SDA = drive ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one delayed copy for edge detection, idle-high on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], I2C_SCL};
      sda_sync <= {sda_sync[0], I2C_SDA};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      shreg      <= 8'h00;
      drive      <= 1'b0;
      phase      <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      shreg      <= n_shreg;
      drive      <= n_drive;
      phase      <= n_phase;
      rx_data    <= n_rx_data;
      rx_valid   <= n_rx_valid;
      tx_req     <= n_tx_req;
      addr_match <= n_match;
      busy       <= n_busy;
    end
  end

  // Next-state logic: bus conditions first, then sample on SCL rise, drive on SCL fall
  always_comb begin
    n_state    = state;
    n_cnt      = cnt;
    n_shreg    = shreg;
    n_drive    = drive;
    n_phase    = phase;
    n_rx_data  = rx_data;
    n_rx_valid = 1'b0;
    n_tx_req   = 1'b0;
    n_match    = addr_match;
    n_busy     = busy;
    load_tx    = 1'b0;

    if (stop_det) begin
      n_state = IDLE;
      n_drive = 1'b0;
      n_match = 1'b0;
      n_busy  = 1'b0;
    end else if (start_det) begin
      n_state = ADDR_HI;
      n_cnt   = 3'd0;
      n_drive = 1'b0;
      n_busy  = 1'b1;
    end else if (scl_rise) begin
      case (state)
        ADDR_HI, ADDR_LO, RX_BYTE: begin
          n_shreg = byte_in;
          n_cnt   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (state == ADDR_HI) begin
              // A read header is only honoured once the full address was matched by a write header
              n_state = (hi_ok && (!byte_in[0] || addr_match)) ? ACK_HI : WAIT;
            end else if (state == ADDR_LO) begin
              n_match = (byte_in == ADDR[7:0]);
              n_state = (byte_in == ADDR[7:0]) ? ACK_LO : WAIT;
            end else begin
              n_rx_data  = byte_in;
              n_rx_valid = 1'b1;
              n_state    = ACK_RX;
            end
          end
        end
        TX_BYTE: begin
          n_cnt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            n_state = ACK_TX;
            n_phase = 1'b0;
          end
        end
        ACK_TX: begin
          // Master NACK ends the read; ACK arms the next byte at the coming fall
          if (sda) n_state = WAIT;
          else     n_phase = 1'b1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ACK_HI, ACK_LO, ACK_RX: begin
          // First fall pulls SDA low, second fall releases it and ends the slot
          if (!drive) begin
            n_drive = 1'b1;
          end else begin
            n_drive = 1'b0;
            if (state == ACK_HI && shreg[0]) load_tx = 1'b1;
            else if (state == ACK_HI)        n_state = ADDR_LO;
            else                             n_state = RX_BYTE;
          end
        end
        TX_BYTE: begin
          n_shreg = {shreg[6:0], 1'b0};
          n_drive = ~shreg[6];
        end
        ACK_TX: begin
          if (!phase) n_drive = 1'b0;
          else        load_tx = 1'b1;
        end
        default: ;
      endcase
      if (load_tx) begin
        n_state  = TX_BYTE;
        n_cnt    = 3'd0;
        n_shreg  = tx_data;
        n_drive  = ~tx_data[7];
        n_tx_req = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_10bit.sv
// tb/tb_i2c_target_10bit.sv - bit-banged I2C master bench with transaction-level reference model
module tb_i2c_target_10bit;

  localparam logic [9:0] ADDR = 10'h2A5;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire sda_bus;
  logic tx_req, rx_valid, addr_match, busy;
  logic [7:0] rx_data;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_target_10bit dut (
    .clk(clk), .rst_n(rst_n), .I2C_SCL(scl), .I2C_SDA(sda_bus),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_match(addr_match), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [7:0] rx_seen[$];
  int tx_req_cnt = 0, rx_wide = 0, tx_wide = 0, both = 0;
  logic rx_prev = 1'b0, tx_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) rx_seen.push_back(rx_data);
    if (tx_req) tx_req_cnt <= tx_req_cnt + 1;
    if (rx_valid && rx_prev) rx_wide <= rx_wide + 1;
    if (tx_req && tx_prev) tx_wide <= tx_wide + 1;
    if (tx_req && rx_valid) both <= both + 1;
    rx_prev <= rx_valid;
    tx_prev <= tx_req;
  end

  // Reference model: which header bytes the target should acknowledge
  logic [7:0] hi_w, hi_r;
  function automatic bit hi_ack(input logic [7:0] b, input bit matched);
    return (b[7:3] == 5'b11110) && (b[2:1] == ADDR[9:8]) && (!b[0] || matched);
  endfunction

  task automatic hc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start;
    m_low = 1'b0; hc(Q);
    scl = 1'b1; hc(Q);
    m_low = 1'b1; hc(Q);
    scl = 1'b0; hc(Q);
  endtask

  task automatic m_stop;
    m_low = 1'b1; hc(Q);
    scl = 1'b1; hc(Q);
    m_low = 1'b0; hc(Q);
  endtask

  task automatic m_bit(input logic b);
    m_low = !b; hc(Q);
    scl = 1'b1; hc(2 * Q);
    scl = 1'b0; hc(Q);
  endtask

  task automatic m_rbit(output logic r);
    m_low = 1'b0; hc(Q);
    scl = 1'b1; hc(Q);
    r = sda_bus; hc(Q);
    scl = 1'b0; hc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    m_rbit(ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_rbit(d[i]);
      if (i == 7) tx_data = next_tx;
    end
    m_bit(nack);
  endtask

  logic [7:0] wq[$];
  logic [7:0] rq[$];

  task automatic txn_write(input logic [7:0] lo);
    logic ack;
    bit m;
    logic [7:0] exp_rx[$];
    rx_seen.delete();
    m_start;
    check("busy_start", busy, 1);
    write_byte(hi_w, ack);
    check("ack_hi_w", ack, 0);
    write_byte(lo, ack);
    m = (lo == ADDR[7:0]);
    check("ack_lo", ack, !m);
    check("match_lo", addr_match, m);
    foreach (wq[i]) begin
      write_byte(wq[i], ack);
      check("ack_data", ack, !m);
      if (m) exp_rx.push_back(wq[i]);
    end
    m_stop;
    check("busy_stop", busy, 0);
    check("match_stop", addr_match, 0);
    check("rx_count", rx_seen.size(), exp_rx.size());
    foreach (exp_rx[i]) if (i < rx_seen.size()) check("rx_data", rx_seen[i], exp_rx[i]);
  endtask

  task automatic txn_read;
    logic ack;
    logic [7:0] d;
    int t0;
    rx_seen.delete();
    m_start;
    write_byte(hi_w, ack); check("rd_ack_hi_w", ack, 0);
    write_byte(ADDR[7:0], ack); check("rd_ack_lo", ack, 0);
    m_start;
    check("match_hold_sr", addr_match, 1);
    tx_data = rq[0];
    t0 = tx_req_cnt;
    write_byte(hi_r, ack);
    check("ack_hi_r", ack, !hi_ack(hi_r, 1'b1));
    for (int i = 0; i < rq.size(); i++) begin
      read_byte(i == rq.size() - 1, (i + 1 < rq.size()) ? rq[i + 1] : 8'hFF, d);
      check("tx_byte", d, rq[i]);
    end
    check("sda_rel_nack", sda_bus, 1);
    check("tx_req_count", tx_req_cnt - t0, rq.size());
    m_stop;
    check("rd_rx_none", rx_seen.size(), 0);
    check("rd_busy_stop", busy, 0);
  endtask

  task automatic txn_nomatch(input logic [7:0] hi, input logic [7:0] b2);
    logic ack;
    int t0;
    rx_seen.delete();
    t0 = tx_req_cnt;
    m_start;
    write_byte(hi, ack);
    check("nm_ack_hi", ack, !hi_ack(hi, 1'b0));
    write_byte(b2, ack);
    check("nm_ack_b2", ack, 1);
    check("nm_busy", busy, 1);
    check("nm_match", addr_match, 0);
    m_stop;
    check("nm_tx_req", tx_req_cnt - t0, 0);
    check("nm_rx_none", rx_seen.size(), 0);
  endtask

  task automatic txn_abort(input int nbits);
    logic ack;
    rx_seen.delete();
    m_start;
    write_byte(hi_w, ack);
    write_byte(ADDR[7:0], ack);
    check("ab_match", addr_match, 1);
    for (int i = 0; i < nbits; i++) m_bit(1'($urandom_range(0, 1)));
    m_stop;
    check("ab_rx_none", rx_seen.size(), 0);
    check("ab_busy", busy, 0);
    check("ab_match_clr", addr_match, 0);
  endtask

  initial begin
    logic ack;
    int kind, n;
    logic [7:0] b;
    hi_w = {5'b11110, ADDR[9:8], 1'b0};
    hi_r = {5'b11110, ADDR[9:8], 1'b1};
    hc(4);
    check("rst_sda", sda_bus, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_match", addr_match, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    hc(4);

    wq = '{8'h3C, 8'h7E};
    txn_write(ADDR[7:0]);
    wq = '{8'h11};
    txn_write(8'hA6);
    rq = '{8'h96, 8'h5A};
    txn_read;
    txn_nomatch(8'hF5, 8'($urandom));
    txn_nomatch(8'hF6, 8'h00);
    txn_abort(4);

    // Reset while the target pulls SDA low for a 0 data bit
    m_start;
    write_byte(hi_w, ack);
    write_byte(ADDR[7:0], ack);
    m_start;
    tx_data = 8'h00;
    write_byte(hi_r, ack);
    check("tx_drive0", sda_bus, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda", sda_bus, 1);
    check("rst_mid_match", addr_match, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rx_data", rx_data, 0);
    check("rst_mid_tx_req", tx_req, 0);
    hc(2);
    rst_n = 1'b1;
    hc(2);
    m_stop;
    wq = '{8'hA1, 8'h5E};
    txn_write(ADDR[7:0]);

    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          wq.delete();
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          b = ($urandom_range(0, 3) != 0) ? ADDR[7:0] : 8'($urandom);
          txn_write(b);
        end
        1: begin
          rq.delete();
          for (int i = 0; i < n; i++) rq.push_back(8'($urandom));
          txn_read;
        end
        2: begin
          b = 8'($urandom);
          if (hi_ack(b, 1'b0)) b = b ^ 8'h08;
          txn_nomatch(($urandom_range(0, 1) != 0) ? hi_r : b, 8'($urandom));
        end
        default: txn_abort($urandom_range(1, 7));
      endcase
    end

    check("rx_pulse_width", rx_wide, 0);
    check("tx_pulse_width", tx_wide, 0);
    check("rx_tx_same_cycle", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
